// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the display scan controller slice.
package display_pkg;

  // Active-low pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One entry of the digit register bank.
  typedef struct packed {
    logic [2:0] value;
    logic       dp;
  } digit_t;

  // Per-slot scan phase.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/display_scan_controller_if.sv
// Write/commit bus between the game/status logic and the scan controller.
interface display_scan_controller_if;

  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic       wr_dp;
  logic       commit;
  logic       commit_ack;

  // Producer of digit values.
  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output wr_dp,
    output commit,
    input  commit_ack
  );

  // The scan controller.
  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  wr_dp,
    input  commit,
    output commit_ack
  );

endinterface

// File: rtl/display_scan_controller_decoder.sv
// Shared 3-bit value to active-low seven-segment decoder, {a,b,c,d,e,f,g}.
module digit_decoder
  import display_pkg::*;
(
  input  logic [2:0] value,
  input  logic       dp,
  output logic [6:0] seg_n
);

  // Glyph table; a disabled digit or value 0 stays dark.
  always_comb begin
    seg_n = SEG_BLANK;
    if (dp) begin
      case (value)
        3'b000:  seg_n = SEG_BLANK;   // blank
        3'b001:  seg_n = 7'b0000110;  // '3'
        3'b010:  seg_n = 7'b0010010;  // '2'
        3'b011:  seg_n = 7'b1001111;  // '1'
        3'b100:  seg_n = 7'b0000001;  // '0'
        3'b101:  seg_n = 7'b0110000;  // 'E'
        3'b110:  seg_n = 7'b0011000;  // 'P'
        3'b111:  seg_n = 7'b1111110;  // '-'
        default: seg_n = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller: double-buffered digit bank, slot/digit
// counters, blank/show FSM and registered segment/anode outputs.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  display_scan_controller_if.slave  bus,
  output logic                      frame_tick,
  output logic [6:0]                seg_n,
  output logic [NUM_DIGITS-1:0]     dig_n
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  scan_state_e           state_q, state_d;
  digit_t                shadow_q [NUM_DIGITS];
  digit_t                shadow_d [NUM_DIGITS];
  digit_t                active_q [NUM_DIGITS];
  digit_t                active_d [NUM_DIGITS];
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  commit_ack_q, commit_ack_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  cnt_wrap;
  logic                  idx_wrap;
  logic                  boundary;
  logic                  do_copy;
  logic                  wr_hit;
  digit_t                cur_digit;
  logic [6:0]            dec_seg;

  assign cur_digit = active_q[idx_q];

  digit_decoder u_dec (
    .value (cur_digit.value),
    .dp    (cur_digit.dp),
    .seg_n (dec_seg)
  );

  // Slot counter, digit index and the blank/show phase of the next cycle.
  always_comb begin
    cnt_wrap = (cnt_q == CNT_W'(SCAN_DIV - 1));
    idx_wrap = (idx_q == IDX_W'(NUM_DIGITS - 1));
    boundary = cnt_wrap & idx_wrap;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_wrap) begin
      cnt_d = '0;
      idx_d = idx_wrap ? '0 : idx_q + 1'b1;
    end
    state_d = (cnt_d < CNT_W'(BLANK_CYCLES)) ? BLANK : SHOW;
  end

  // Shadow writes and the frame-boundary copy into the active bank.
  // The copy reads shadow_q, so a same-edge write only reaches shadow.
  always_comb begin
    wr_hit    = bus.wr_en && (32'(bus.wr_addr) < NUM_DIGITS);
    do_copy   = boundary && (pending_q || bus.commit);
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = (pending_q || bus.commit) && !boundary;
    if (wr_hit) begin
      shadow_d[IDX_W'(bus.wr_addr)] = '{value: bus.wr_data, dp: bus.wr_dp};
    end
    if (do_copy) begin
      active_d = shadow_q;
    end
  end

  // Output decode from the current phase; registered below.
  always_comb begin
    seg_d        = SEG_BLANK;
    dig_d        = '1;
    commit_ack_d = do_copy;
    frame_tick_d = boundary;
    if (state_q == SHOW) begin
      seg_d = dec_seg;
      dig_d = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= BLANK;
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      dig_q        <= '1;
      commit_ack_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      commit_ack_q <= commit_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_n          = seg_q;
  assign dig_n          = dig_q;
  assign frame_tick     = frame_tick_q;
  assign bus.commit_ack = commit_ack_q;

endmodule
